// File: rtl/mem_io_unit.sv
// Data RAM plus a small memory-mapped I/O page (GPIO, prescaled timer, status snapshot)
// sitting downstream of the 16-bit core; reads are combinational, writes take effect on the clock.
module mem_io_unit #(
    parameter int RAM_AW   = 12,
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic [15:0] datain,
    input  logic        mem_wr,
    input  logic [7:0]  status,
    input  logic [15:0] gpio_in,
    output logic [15:0] dout,
    output logic [15:0] gpio_out,
    output logic        timer_irq
);

    localparam logic [16:0] RAM_WORDS = 17'd1 << RAM_AW;
    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    logic [15:0] r_ram [0:(2**RAM_AW)-1];
    logic [15:0] r_gpio_out;
    logic [15:0] r_sync1;
    logic [15:0] r_sync2;
    logic [15:0] r_tcount;
    logic [15:0] r_tcmp;
    logic [15:0] r_presc;
    logic        r_en;
    logic        r_match;
    logic        r_irqen;
    logic        r_irq;
    logic [7:0]  r_stat;

    logic        w_ram_sel;
    logic        w_wr_ram;
    logic        w_wr_gpio;
    logic        w_wr_tcount;
    logic        w_wr_tcmp;
    logic        w_wr_tctrl;
    logic        w_wr_stat;
    logic        w_tick;
    logic        w_match_set;
    logic [15:0] w_tcount_nxt;
    logic [15:0] w_presc_nxt;
    logic        w_match_nxt;
    logic        w_irqen_nxt;

    assign w_ram_sel   = ({1'b0, address} < RAM_WORDS);
    assign w_wr_ram    = mem_wr && w_ram_sel;
    assign w_wr_gpio   = mem_wr && (address == 16'hFF00);
    assign w_wr_tcount = mem_wr && (address == 16'hFF02);
    assign w_wr_tcmp   = mem_wr && (address == 16'hFF03);
    assign w_wr_tctrl  = mem_wr && (address == 16'hFF04);
    assign w_wr_stat   = mem_wr && (address == 16'hFF05);
    assign w_tick      = r_en && (r_presc == PRESC_MAX);

    // Timer/prescaler next state: a core write to TCOUNT beats a tick, a MATCH set beats a clear.
    always_comb begin
        w_tcount_nxt = r_tcount;
        w_match_set  = 1'b0;
        if (w_wr_tcount) begin
            w_tcount_nxt = datain;
        end else if (w_tick) begin
            if (r_tcount == r_tcmp) begin
                w_tcount_nxt = 16'h0000;
            end else begin
                w_tcount_nxt = r_tcount + 16'd1;
            end
        end else begin
            w_tcount_nxt = r_tcount;
        end
        w_match_set = w_tick && (r_tcount == r_tcmp);

        if (!r_en || w_tick) begin
            w_presc_nxt = 16'h0000;
        end else begin
            w_presc_nxt = r_presc + 16'd1;
        end

        if (w_match_set) begin
            w_match_nxt = 1'b1;
        end else if (w_wr_tctrl && datain[1]) begin
            w_match_nxt = 1'b0;
        end else begin
            w_match_nxt = r_match;
        end

        if (w_wr_tctrl) begin
            w_irqen_nxt = datain[2];
        end else begin
            w_irqen_nxt = r_irqen;
        end
    end

    // I/O page registers, synchroniser and timer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gpio_out <= 16'h0000;
            r_sync1    <= 16'h0000;
            r_sync2    <= 16'h0000;
            r_tcount   <= 16'h0000;
            r_tcmp     <= 16'hFFFF;
            r_presc    <= 16'h0000;
            r_en       <= 1'b0;
            r_match    <= 1'b0;
            r_irqen    <= 1'b0;
            r_irq      <= 1'b0;
            r_stat     <= 8'h00;
        end else begin
            r_sync1  <= gpio_in;
            r_sync2  <= r_sync1;
            r_tcount <= w_tcount_nxt;
            r_presc  <= w_presc_nxt;
            r_match  <= w_match_nxt;
            r_irqen  <= w_irqen_nxt;
            r_irq    <= w_match_nxt & w_irqen_nxt;
            if (w_wr_gpio) begin
                r_gpio_out <= datain;
            end
            if (w_wr_tcmp) begin
                r_tcmp <= datain;
            end
            if (w_wr_tctrl) begin
                r_en <= datain[0];
            end
            if (w_wr_stat) begin
                r_stat <= status;
            end
        end
    end

    // Data RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_ram[address[RAM_AW-1:0]] <= datain;
        end
    end

    // Combinational read mux.
    always_comb begin
        dout = 16'h0000;
        if (w_ram_sel) begin
            dout = r_ram[address[RAM_AW-1:0]];
        end else begin
            case (address)
                16'hFF00: dout = r_gpio_out;
                16'hFF01: dout = r_sync2;
                16'hFF02: dout = r_tcount;
                16'hFF03: dout = r_tcmp;
                16'hFF04: dout = {13'd0, r_irqen, r_match, r_en};
                16'hFF05: dout = {8'd0, r_stat};
                default:  dout = 16'h0000;
            endcase
        end
    end

    assign gpio_out  = r_gpio_out;
    assign timer_irq = r_irq;

endmodule

// File: tb/tb_mem_io_unit.sv
// Directed bench for mem_io_unit: one PRESCALE=1 and one PRESCALE=4 instance share inputs;
// expectations are queued when stimulus is applied and popped when the output is sampled.
module tb_mem_io_unit;

    logic        clk;
    logic        rst;
    logic [15:0] address;
    logic [15:0] datain;
    logic        mem_wr;
    logic [7:0]  status;
    logic [15:0] gpio_in;
    logic [15:0] dout1, gpio_out1, dout4, gpio_out4;
    logic        irq1, irq4;

    int          n_tests = 0;
    int          n_fail  = 0;
    string       tag_q[$];
    logic [15:0] exp_q[$];

    mem_io_unit #(.RAM_AW(12), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .address(address), .datain(datain), .mem_wr(mem_wr),
        .status(status), .gpio_in(gpio_in), .dout(dout1), .gpio_out(gpio_out1), .timer_irq(irq1)
    );

    mem_io_unit #(.RAM_AW(12), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .address(address), .datain(datain), .mem_wr(mem_wr),
        .status(status), .gpio_in(gpio_in), .dout(dout4), .gpio_out(gpio_out4), .timer_irq(irq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string t, input logic [15:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [15:0] obs);
        string       t;
        logic [15:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    // One write cycle: the write lands on the next rising edge; returns at the following negedge.
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        address = a;
        datain  = d;
        mem_wr  = 1'b1;
        @(negedge clk);
        mem_wr  = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e, input string t);
        address = a;
        push(t, e);
        #1;
        pop_chk(dout1);
    endtask

    task automatic rd4(input logic [15:0] a, input logic [15:0] e, input string t);
        address = a;
        push(t, e);
        #1;
        pop_chk(dout4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; address = 16'h0000; datain = 16'h0000; mem_wr = 1'b0;
        status = 8'h00; gpio_in = 16'h0000;
        #1;
        push("rst_gpio_out", 16'h0000); #1; pop_chk(gpio_out1);
        push("rst_irq", 16'h0000); pop_chk({15'd0, irq1});
        push("rst_gpio_out4", 16'h0000); pop_chk(gpio_out4);
        push("rst_irq4", 16'h0000); pop_chk({15'd0, irq4});
        rd(16'hFF02, 16'h0000, "rst_tcount");
        rd(16'hFF03, 16'hFFFF, "rst_tcmp");
        rd(16'hFF04, 16'h0000, "rst_tctrl");
        rd(16'hFF05, 16'h0000, "rst_stat");
        rd(16'hFF01, 16'h0000, "rst_gpio_in");
        @(negedge clk);
        rst = 1'b0;

        // RAM
        wr(16'h0010, 16'hA5A5);
        wr(16'h0FFF, 16'h1234);
        wr(16'h0000, 16'h1111);
        rd(16'h0010, 16'hA5A5, "ram_0010");
        rd(16'h0FFF, 16'h1234, "ram_0fff");
        rd(16'h1000, 16'h0000, "unmapped_1000");
        wr(16'h1000, 16'h7777);
        rd(16'h0000, 16'h1111, "ram_no_alias");
        rd(16'h1000, 16'h0000, "unmapped_after_wr");
        rd(16'hFF06, 16'h0000, "unmapped_ff06");

        // GPIO
        wr(16'hFF00, 16'hBEEF);
        push("gpio_out", 16'hBEEF); #1; pop_chk(gpio_out1);
        rd(16'hFF00, 16'hBEEF, "gpio_out_rd");
        wr(16'hFF01, 16'hFFFF);
        rd(16'hFF01, 16'h0000, "gpio_in_ro");
        gpio_in = 16'h00F0;
        rd(16'hFF01, 16'h0000, "gpio_in_e0");
        @(negedge clk);
        rd(16'hFF01, 16'h0000, "gpio_in_e1");
        @(negedge clk);
        rd(16'hFF01, 16'h00F0, "gpio_in_e2");

        // Timer, PRESCALE=1
        wr(16'hFF03, 16'h0003);
        wr(16'hFF04, 16'h0005);
        rd(16'hFF02, 16'h0000, "tcount_e0");
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            rd(16'hFF02, 16'(k), "tcount_seq");
        end
        @(negedge clk);
        rd(16'hFF02, 16'h0000, "tcount_match");
        rd(16'hFF04, 16'h0007, "tctrl_match");
        push("irq_match", 16'h0001); pop_chk({15'd0, irq1});
        wr(16'hFF04, 16'h0007);
        rd(16'hFF04, 16'h0005, "match_clr");
        push("irq_clr", 16'h0000); pop_chk({15'd0, irq1});
        rd(16'hFF02, 16'h0001, "tcount_after_clr");
        @(negedge clk);
        @(negedge clk);
        rd(16'hFF02, 16'h0003, "pre_collide");
        wr(16'hFF04, 16'h0007);
        rd(16'hFF04, 16'h0007, "set_beats_clr");
        rd(16'hFF02, 16'h0000, "collide_tcount");
        push("irq_collide", 16'h0001); pop_chk({15'd0, irq1});
        wr(16'hFF02, 16'h0100);
        rd(16'hFF02, 16'h0100, "wr_beats_tick");
        @(negedge clk);
        rd(16'hFF02, 16'h0101, "tick_after_wr");
        wr(16'hFF04, 16'h0007);
        rd(16'hFF04, 16'h0005, "clr2");
        wr(16'hFF02, 16'hFFFF);
        rd(16'hFF02, 16'hFFFF, "pre_wrap");
        @(negedge clk);
        rd(16'hFF02, 16'h0000, "wrap");
        rd(16'hFF04, 16'h0005, "wrap_nomatch");

        // Prescaler, PRESCALE=4
        wr(16'hFF04, 16'h0000);
        wr(16'hFF02, 16'h0000);
        wr(16'hFF03, 16'h00FF);
        wr(16'hFF04, 16'h0001);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            rd4(16'hFF02, 16'(i / 4), "presc_run");
        end
        wr(16'hFF04, 16'h0000);
        wr(16'hFF04, 16'h0001);
        rd4(16'hFF02, 16'h0002, "presc_reen_e0");
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            rd4(16'hFF02, (i == 4) ? 16'h0003 : 16'h0002, "presc_reen");
        end

        // Status snapshot
        status = 8'h5A;
        wr(16'hFF05, 16'h1234);
        status = 8'hFF;
        rd(16'hFF05, 16'h005A, "stat");

        // Asynchronous reset between edges
        @(posedge clk);
        #2;
        rst = 1'b1;
        push("arst_gpio_out", 16'h0000); #1; pop_chk(gpio_out1);
        push("arst_irq", 16'h0000); pop_chk({15'd0, irq1});
        rd(16'hFF02, 16'h0000, "arst_tcount");
        rd(16'hFF03, 16'hFFFF, "arst_tcmp");
        rd(16'hFF04, 16'h0000, "arst_tctrl");
        rd(16'hFF05, 16'h0000, "arst_stat");
        rd(16'hFF00, 16'h0000, "arst_gpio_rd");
        rd(16'hFF01, 16'h0000, "arst_sync");
        rd(16'h0010, 16'hA5A5, "arst_ram_0010");
        rd(16'h0FFF, 16'h1234, "arst_ram_0fff");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(16'h0010, 16'hA5A5, "post_rst_ram");
        rd(16'hFF02, 16'h0000, "post_rst_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
